word_counter_rsp: RTL
=====================

// Module: word_counter_rsp
// PURPOSE
//  Responder side of the word-counter readout on the PCIe transaction-layer output port.
//  Counts words actually popped from each of the NUM_PORTS output FIFOs. Answers a req/idx query with the
//  selected count and a one-cycle valid pulse. Sits beside the output FIFOs, driven by the same pop and empty
//  signals the downstream consumer uses.
// PARAMETERS
//  NUM_PORTS  4  number of output FIFOs counted
//  IDX_W      2  width of idx, clog2(NUM_PORTS)
//  CNT_W      5  width of each word counter and of contador
// PORTS
//  clk         in   1          system clock, all state updates on posedge
//  reset       in   1          asynchronous, active-high; clears all state
//  init        in   1          configuration phase; holds counters cleared, queries ignored
//  pop         in   NUM_PORTS  per-FIFO pop strobe from consumer
//  fifo_empty  in   NUM_PORTS  per-FIFO empty flag (same cycle as pop)
//  req         in   1          query strobe, sampled each posedge
//  idx         in   IDX_W      counter selected by req
//  contador    out  CNT_W      count of FIFO idx, registered
//  valid       out  1          contador is meaningful this cycle
//  state       out  2          FSM state for debug/coverage
// BEHAVIOUR
//  - Reset values: contador=0, valid=0, state=RESET, all counters=0.
//  - FSM: RESET -> INIT if init else IDLE; INIT -> IDLE when init=0; IDLE -> ACTIVE when any fifo_empty=0;
//    ACTIVE -> IDLE when all fifo_empty=1; any state -> INIT when init=1 (counters cleared in the same edge).
//  - Count rule: counter[i] += 1 on posedge iff pop[i] & ~fifo_empty[i] and state is IDLE or ACTIVE.
//    A pop on an empty FIFO is not counted.
//  - Counters wrap modulo 2^CNT_W (31 -> 0); no overflow flag.
//  - Query: req=1 at edge N in IDLE/ACTIVE -> at edge N+1, contador=counter[idx] value before edge N's
//    increment, valid=1. Otherwise valid=0 and contador keeps its last value.
//  - Back-to-back req every cycle is legal, one response per cycle, fixed latency 1.
//  - req in RESET/INIT: ignored, valid stays 0.
//  - Simultaneous pop and req on the same index: the response shows the pre-increment count; the increment
//    still takes effect.
//  - Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).
//  - Counters never change except by counted pops, INIT, reset, or the optional clear below.
// CONFIGURATION
//  WORD_COUNTER_CLEAR_ON_READ_EN
//   - Defined: a served req clears counter[idx]. The next value is 0, plus 1 if a pop was counted in the
//     same cycle. contador still returns the pre-clear value.
//   - Undefined: reads are non-destructive; counters are cleared only by reset or INIT.
// STRUCTURE
//  - Package word_counter_pkg: state encoding RESET=2'd0, INIT=2'd1, IDLE=2'd2, ACTIVE=2'd3; default
//    widths for NUM_PORTS, IDX_W, CNT_W.
//  - Sub-module word_counter_slice (one per FIFO, generate loop).
//    Inputs: clk, reset, en, inc, clr. Output: cnt[CNT_W-1:0].
//    Handles wrap and increment/clear priority.
//  - Top level contains the FSM, the idx mux and the output registers.
// TESTING
//  1. reset=1, then init=1 for 3 cycles, then init=0; req idx=0..3 -> valid after 1 cycle, contador=0 each;
//     state goes RESET->INIT->IDLE.
//  2. 5 pops FIFO0, 3 pops FIFO1 with empty=0; pop FIFO2 with empty=1 -> reads give 5, 3, 0, 0.
//  3. 33 counted pops on FIFO3 -> contador=1 (wrap).
//  4. req idx=1 in the same cycle as a counted pop on FIFO1, count=4 -> contador=4; next req -> 5 (macro off);
//     with the macro on: first read 4, next read 1.
//  5. req asserted during INIT -> valid stays 0; re-entering INIT from ACTIVE zeros all counters.
//  6. Assert reset while valid=1 and counters nonzero -> valid=0, contador=0, state=RESET with no clock edge.

Source files
------------

// File: rtl/word_counter_pkg.sv
// word_counter_pkg: FSM state encoding and default widths shared by the
// word-counter readout responder and its per-FIFO counter slices.
package word_counter_pkg;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_IDLE   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

   localparam int NUM_PORTS_DEF = 4;
   localparam int IDX_W_DEF     = 2;
   localparam int CNT_W_DEF     = 5;

   function automatic logic is_run(input state_t s);
      return (s == ST_IDLE) || (s == ST_ACTIVE);
   endfunction

endpackage

// File: rtl/word_counter_slice.sv
// word_counter_slice: one wrapping word counter. A clear wins over an
// increment, but a pop counted in the same cycle survives the clear.
module word_counter_slice
   import word_counter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic hit;

   assign hit = en & inc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= CNT_W'(hit);
      end else if (hit) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/word_counter_rsp.sv
// word_counter_rsp: counts words popped per output FIFO and answers
// req/idx queries. `WORD_COUNTER_CLEAR_ON_READ_EN makes reads destructive.
module word_counter_rsp
   import word_counter_pkg::*;
#(
   parameter int NUM_PORTS = NUM_PORTS_DEF,
   parameter int IDX_W     = IDX_W_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 init,
   input  logic [NUM_PORTS-1:0] pop,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic                 req,
   input  logic [IDX_W-1:0]     idx,
   output logic [CNT_W-1:0]     contador,
   output logic                 valid,
   output logic [1:0]           state
);

   state_t               state_q;
   state_t               state_d;
   logic                 run;
   logic                 served;
   logic                 cnt_en;
   logic [NUM_PORTS-1:0] rd_clr;
   logic [CNT_W-1:0]     cnt [NUM_PORTS];

   assign run    = is_run(state_q);
   assign served = req & run;
   // init clears rather than counts, so counting is masked while it is high
   assign cnt_en = run & ~init;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (init) begin
         state_d = ST_INIT;
      end else begin
         unique case (state_q)
            ST_RESET,
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE:   if (!(&fifo_empty)) state_d = ST_ACTIVE;
            ST_ACTIVE: if (&fifo_empty) state_d = ST_IDLE;
            default:   state_d = ST_RESET;
         endcase
      end
   end

`ifdef WORD_COUNTER_CLEAR_ON_READ_EN
   always_comb begin
      rd_clr = '0;
      if (served) rd_clr[idx] = 1'b1;
   end
`else
   assign rd_clr = '0;
`endif

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
      word_counter_slice #(
         .CNT_W (CNT_W)
      ) u_slice (
         .clk   (clk),
         .reset (reset),
         .en    (cnt_en),
         .inc   (pop[i] & ~fifo_empty[i]),
         .clr   (init | rd_clr[i]),
         .cnt   (cnt[i])
      );
   end

   // response carries the count as it stood before this edge's update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         contador <= '0;
         valid    <= 1'b0;
      end else begin
         valid <= served;
         if (served) contador <= cnt[idx];
      end
   end

   assign state = state_q;

endmodule
